// File: rtl/exp_pkg.sv
// Shared constants, types and the 2^f chord table for the GELU exponent range reducer.
package exp_pkg;

  localparam int unsigned Q         = 26;
  localparam int unsigned W         = 32;
  localparam int unsigned INT_WIDTH = 5;
  localparam int unsigned SEG_BITS  = 3;
  localparam int unsigned NUM_SEG   = 1 << SEG_BITS;

  typedef logic signed [W-1:0]         q_t;
  typedef logic signed [INT_WIDTH-1:0] int_t;
  typedef logic        [Q-1:0]         frac_t;
  typedef logic        [SEG_BITS-1:0]  seg_t;

  // round(log2(e) * 2^26)
  localparam q_t LOG2E_Q = 32'sd96817625;

  // Chord of 2^f over [i/8, (i+1)/8), applied to the full fraction: 2^f ~= f*k + b.
  localparam q_t K_LUT [NUM_SEG] = '{
    32'sd48590969, 32'sd52988827, 32'sd57784726, 32'sd63014691,
    32'sd68718007, 32'sd74937518, 32'sd81719943, 32'sd89116230
  };

  localparam q_t B_LUT [NUM_SEG] = '{
    32'sd67108864, 32'sd66559132, 32'sd65360157, 32'sd63398920,
    32'sd60547262, 32'sd56660068, 32'sd51573249, 32'sd45101498
  };

endpackage

// File: rtl/exp_range_reducer_if.sv
// Operand-in / reduced-exponent-out bundle between the range reducer and its neighbours.
interface exp_range_reducer_if;
  import exp_pkg::*;

  logic  valid_in;
  q_t    x_in;
  logic  valid_out;
  int_t  integer_part;
  frac_t frac_part;
  q_t    k_coeff;
  q_t    b_intercept;

  modport master (
    output valid_in,
    output x_in,
    input  valid_out,
    input  integer_part,
    input  frac_part,
    input  k_coeff,
    input  b_intercept
  );

  modport slave (
    input  valid_in,
    input  x_in,
    output valid_out,
    output integer_part,
    output frac_part,
    output k_coeff,
    output b_intercept
  );

endinterface

// File: rtl/exp_pwl_lut.sv
// Combinational segment -> {slope, intercept} lookup for the piecewise-linear 2^f.
module exp_pwl_lut
  import exp_pkg::*;
(
  input  seg_t seg_i,
  output q_t   k_o,
  output q_t   b_o
);

  always_comb begin
    k_o = K_LUT[seg_i];
    b_o = B_LUT[seg_i];
  end

endmodule

// File: rtl/exp_range_reducer.sv
// Three-stage reducer: t = x*log2(e), split into saturated floor(t) and fraction, then
// fetch the 2^f chord coefficients so all four EU operands leave in the same cycle.
module exp_range_reducer
  import exp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  exp_range_reducer_if.slave rr_io
);

  localparam logic signed [2*W-1:0] IpMax = (64'sd1 <<< (INT_WIDTH - 1)) - 64'sd1;
  localparam logic signed [2*W-1:0] IpMin = -(64'sd1 <<< (INT_WIDTH - 1));
  localparam int_t IntMax = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam int_t IntMin = {1'b1, {(INT_WIDTH-1){1'b0}}};

  // Stage 1: full-precision product, 2Q fractional bits
  logic signed [2*W-1:0] prod_d;
  logic signed [2*W-1:0] prod_q;
  logic                  v1_q;

  assign prod_d = $signed({{W{rr_io.x_in[W-1]}}, rr_io.x_in}) *
                  $signed({{W{1'b0}}, LOG2E_Q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      prod_q <= '0;
    end else begin
      v1_q <= rr_io.valid_in;
      if (rr_io.valid_in) begin
        prod_q <= prod_d;
      end
    end
  end

  // Stage 2: range split; saturation judged on the untruncated floor so nothing wraps
  logic signed [2*W-1:0] ip_full;
  int_t                  int_d;
  int_t                  int_q;
  frac_t                 fr_d;
  frac_t                 fr_q;
  logic                  v2_q;

  assign ip_full = prod_q >>> (2 * Q);

  always_comb begin
    int_d = ip_full[INT_WIDTH-1:0];
    fr_d  = prod_q[2*Q-1:Q];
    if (ip_full > IpMax) begin
      int_d = IntMax;
      fr_d  = '1;
    end else if (ip_full < IpMin) begin
      int_d = IntMin;
      fr_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      int_q <= '0;
      fr_q  <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        int_q <= int_d;
        fr_q  <= fr_d;
      end
    end
  end

  // Stage 3: coefficient fetch, everything registered together
  seg_t  seg;
  q_t    k_lut;
  q_t    b_lut;
  logic  v3_q;
  int_t  int3_q;
  frac_t fr3_q;
  q_t    k3_q;
  q_t    b3_q;

  assign seg = fr_q[Q-1 -: SEG_BITS];

  exp_pwl_lut u_lut (
    .seg_i (seg),
    .k_o   (k_lut),
    .b_o   (b_lut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q   <= 1'b0;
      int3_q <= '0;
      fr3_q  <= '0;
      k3_q   <= '0;
      b3_q   <= '0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        int3_q <= int_q;
        fr3_q  <= fr_q;
        k3_q   <= k_lut;
        b3_q   <= b_lut;
      end
    end
  end

  assign rr_io.valid_out    = v3_q;
  assign rr_io.integer_part = int3_q;
  assign rr_io.frac_part    = fr3_q;
  assign rr_io.k_coeff      = k3_q;
  assign rr_io.b_intercept  = b3_q;

endmodule

// File: tb/tb_exp_range_reducer.sv
// Directed and table-driven bench for exp_range_reducer with a latency-tagged scoreboard.
module tb_exp_range_reducer;

  typedef struct packed {
    logic [4:0]  ip;
    logic [25:0] fr;
    logic [31:0] k;
    logic [31:0] b;
  } res_t;

  localparam logic [31:0] K_TAB [8] = '{
    32'd48590969, 32'd52988827, 32'd57784726, 32'd63014691,
    32'd68718007, 32'd74937518, 32'd81719943, 32'd89116230
  };
  localparam logic [31:0] B_TAB [8] = '{
    32'd67108864, 32'd66559132, 32'd65360157, 32'd63398920,
    32'd60547262, 32'd56660068, 32'd51573249, 32'd45101498
  };

  logic clk;
  logic rst_n;
  exp_range_reducer_if rr ();

  exp_range_reducer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rr_io (rr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_checks = 0;
  int   n_errors = 0;
  int   edges    = 0;
  int   due_q[$];
  res_t res_q[$];
  res_t last;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  function automatic res_t model(input logic [31:0] x);
    res_t   r;
    longint p;
    longint ip;
    logic [2:0] seg;
    p  = longint'($signed(x)) * 64'sd96817625;
    ip = p >>> 52;
    if (ip > 15) begin
      r.ip = 5'b01111;
      r.fr = '1;
    end else if (ip < -16) begin
      r.ip = 5'b10000;
      r.fr = '0;
    end else begin
      r.ip = ip[4:0];
      r.fr = p[51:26];
    end
    seg = r.fr[25:23];
    r.k = K_TAB[seg];
    r.b = B_TAB[seg];
    return r;
  endfunction

  task automatic sample();
    logic exp_v;
    exp_v = (due_q.size() != 0) && (due_q[0] == edges);
    if (exp_v) begin
      last = res_q.pop_front();
      void'(due_q.pop_front());
    end
    check_val("valid_out", {63'd0, rr.valid_out}, {63'd0, exp_v});
    check_val("integer_part", {59'd0, rr.integer_part}, {59'd0, last.ip});
    check_val("frac_part", {38'd0, rr.frac_part}, {38'd0, last.fr});
    check_val("k_coeff", {32'd0, rr.k_coeff}, {32'd0, last.k});
    check_val("b_intercept", {32'd0, rr.b_intercept}, {32'd0, last.b});
  endtask

  // Drive one cycle; a valid operand is expected back after the third following edge.
  task automatic tick(input logic v, input logic [31:0] x, input logic use_dir, input res_t dir);
    rr.valid_in = v;
    rr.x_in     = x;
    if (v) begin
      due_q.push_back(edges + 3);
      res_q.push_back(use_dir ? dir : model(x));
    end
    @(posedge clk);
    edges++;
    #1;
    sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'hDEAD_BEEF, 1'b0, '0);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] x;
    rst_n       = 1'b1;
    rr.valid_in = 1'b0;
    rr.x_in     = '0;
    last        = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst valid_out", {63'd0, rr.valid_out}, 64'd0);
    check_val("rst integer_part", {59'd0, rr.integer_part}, 64'd0);
    check_val("rst frac_part", {38'd0, rr.frac_part}, 64'd0);
    check_val("rst k_coeff", {32'd0, rr.k_coeff}, 64'd0);
    check_val("rst b_intercept", {32'd0, rr.b_intercept}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Directed vectors with hand-derived results
    tick(1'b1, 32'h0000_0000, 1'b1, '{5'd0, 26'd0, 32'd48590969, 32'd67108864});
    idle(4);
    tick(1'b1, 32'h0400_0000, 1'b1, '{5'b00001, 26'h1C551D9, 32'd63014691, 32'd63398920});
    tick(1'b1, 32'hFC00_0000, 1'b1, '{5'b11110, 26'd37400103, 32'd68718007, 32'd60547262});
    tick(1'b1, 32'hB000_0000, 1'b1, '{5'b10000, 26'd0, 32'd48590969, 32'd67108864});
    tick(1'b1, 32'h3C00_0000, 1'b1, '{5'b01111, 26'h3FF_FFFF, 32'd89116230, 32'd45101498});
    idle(4);

    // Back-to-back mix of in-range and wide operands
    for (int i = 0; i < 16; i++) begin
      r = $urandom;
      x = (i % 2 == 0) ? {{4{r[27]}}, r[27:0]} : r;
      tick(1'b1, x, 1'b0, '0);
    end
    // Alternating valid/bubble; bubble data must not disturb held outputs
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      tick(1'b1, {{3{r[28]}}, r[28:0]}, 1'b0, '0);
      tick(1'b0, $urandom, 1'b0, '0);
    end
    idle(4);

    // Asynchronous reset with two operands in flight
    tick(1'b1, 32'h0400_0000, 1'b0, '0);
    tick(1'b1, 32'hFC00_0000, 1'b0, '0);
    rr.valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("arst valid_out", {63'd0, rr.valid_out}, 64'd0);
    check_val("arst integer_part", {59'd0, rr.integer_part}, 64'd0);
    check_val("arst frac_part", {38'd0, rr.frac_part}, 64'd0);
    check_val("arst k_coeff", {32'd0, rr.k_coeff}, 64'd0);
    check_val("arst b_intercept", {32'd0, rr.b_intercept}, 64'd0);
    due_q.delete();
    res_q.delete();
    last = '0;
    @(posedge clk);
    edges++;
    #1 rst_n = 1'b1;
    idle(4);
    tick(1'b1, 32'h0400_0000, 1'b1, '{5'b00001, 26'h1C551D9, 32'd63014691, 32'd63398920});
    idle(5);

    check_val("scoreboard drained", 64'(due_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
